max_pool_layer: RTL and testbench
=================================

// Module: max_pool_layer
// PURPOSE
//  Downstream stage of the multi-filter conv layer. Consumes the K flattened feature maps
//  (each H x W) and produces K max-pooled maps, each OH x OW (P x P window, stride P).
//  Sequential scan, one window element per cycle; start/busy/done handshake toward the layer sequencer.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  FLOAT_MODE  1   0: signed integer, 1: IEEE-754 single
//  K           6   number of feature maps (conv filters)
//  H           28  input map height (conv output height)
//  W           28  input map width (conv output width)
//  P           2   pool window size and stride; OH=H/P, OW=W/P (floor)
// PORTS
//  clk    in   1                        clock, rising edge
//  rst    in   1                        synchronous, active-high reset
//  start  in   1                        one-cycle request to pool the current maps
//  maps   in   K*H*W*DATA_WIDTH         ascending [0:N-1]; element (k,r,c) at ((k*H+r)*W+c)*DATA_WIDTH
//  busy   out  1                        high while scanning
//  done   out  1                        one-cycle pulse, res complete
//  res    out  K*OH*OW*DATA_WIDTH       ascending; element (k,i,j) at ((k*OH+i)*OW+j)*DATA_WIDTH
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=IDLE, busy=0, done=0, res=0, all counters=0. Overrides everything, including mid-scan.
//  - FSM: IDLE -(start)-> SCAN -(last element of last window)-> DONE -> IDLE.
//  - DONE lasts exactly 1 cycle (done=1, busy=0).
//  - start outside IDLE is ignored. start in DONE is ignored; resample it in IDLE.
//  - maps must be held stable from the start cycle until done. Not captured internally.
//  - Counters: k, i, j (output position), wr, wc (0..P-1, within window).
//    wc is innermost, then wr, then j, then i, then k.
//  - SCAN cycle, window offset (wr,wc) = (0,0): acc <= x(k, i*P, j*P).
//  - Other offsets: acc <= max(acc, x(k, i*P+wr, j*P+wc)).
//  - On the last offset (P-1,P-1): res(k,i,j) <= max(acc, x). Then advance i, j, k.
//  - Latency: start sampled at edge t. busy=1 for cycles t+1 .. t+K*OH*OW*P*P.
//    done=1 in the following cycle.
//  - Compare, SInt: signed two's complement.
//  - Compare, Float: larger sign-magnitude order.
//    Signs differ: the positive operand wins.
//    Both positive: the larger magnitude wins. Both negative: the smaller magnitude wins.
//    Ties (including +0 vs -0): keep acc. NaN/Inf are not special-cased (bit-pattern order).
//  - H or W not divisible by P: trailing rows/cols beyond OH*P / OW*P are never read.
//  - res holds its value between runs. It is overwritten element by element during a new SCAN.
//    It is valid only after done.
//  - P=1: pure copy (plus ReLU if enabled). Each element takes 1 cycle.
// CONFIGURATION
//  RELU_EN defined: fused ReLU on each value written to res.
//   - Float: sign bit set -> 32'h0 (also maps -0 to +0).
//   - SInt: negative -> 0.
//   - No added latency.
//  RELU_EN undefined: res holds the raw window max.
// TESTING
//  1. rst held 3 cycles mid-SCAN -> busy=0, done=0, res=0 next cycle. No done pulse follows.
//  2. SInt, K=1,H=W=4,P=2.
//     - Stimulus: maps = 1..16 row-major; start.
//     - Response: done at t+17, res = {6,8,14,16}.
//  3. Float, K=1,H=W=2,P=2.
//     - Stimulus: maps = {-3.0,-1.5,-2.0,-0.5}.
//     - Response: res = 0xBF000000 without RELU_EN, 0x00000000 with RELU_EN.
//  4. Float ordering, K=1,H=W=2.
//     - Stimulus: maps = {0x80000000,0x00000000,0xC0000000,0x3F800000}.
//     - Response: res = 0x3F800000.
//  5. Defaults (K=6,H=W=28), random maps.
//     - start -> busy for 4704 cycles, single done pulse; res matches the reference model.
//     - A second start issued during SCAN -> ignored.
//  6. H=W=5,P=2, row 4 / col 4 = 32'h7FFFFFFF.
//     - Response: the large values never appear in res; OH=OW=2.

Source files
------------

// File: rtl/max_pool_layer_if.sv
// Start/busy/done handshake plus flattened map and result buses for max_pool_layer.
// maps and res are ascending vectors; element n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
interface max_pool_layer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28,
  parameter int unsigned P          = 2
) ();
  localparam int unsigned OH = H / P;
  localparam int unsigned OW = W / P;

  logic                           start;
  logic [0:K*H*W*DATA_WIDTH-1]    maps;
  logic                           busy;
  logic                           done;
  logic [0:K*OH*OW*DATA_WIDTH-1]  res;

  modport master (
    output start,
    output maps,
    input  busy,
    input  done,
    input  res
  );

  modport slave (
    input  start,
    input  maps,
    output busy,
    output done,
    output res
  );
endinterface

// File: rtl/max_pool_layer.sv
// Max-pool stage: scans K feature maps one window element per cycle, P x P window, stride P.
// Define RELU_EN to fuse a ReLU onto every value written to res (no added latency).
module max_pool_layer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLOAT_MODE = 1,
  parameter int unsigned K          = 6,
  parameter int unsigned H          = 28,
  parameter int unsigned W          = 28,
  parameter int unsigned P          = 2
) (
  input logic             clk,
  input logic             rst,
  max_pool_layer_if.slave bus
);
  localparam int unsigned OH     = H / P;
  localparam int unsigned OW     = W / P;
  localparam int unsigned MAP_N  = K * H * W * DATA_WIDTH;
  localparam int unsigned RES_N  = K * OH * OW * DATA_WIDTH;
  localparam int unsigned MAP_AW = $clog2(MAP_N);
  localparam int unsigned RES_AW = $clog2(RES_N);
  localparam int unsigned KW     = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned IW     = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned JW     = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned PW     = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [0:RES_N-1]      res_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [KW-1:0]         k_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic [PW-1:0]         wr_q;
  logic [PW-1:0]         wc_q;

  int unsigned           row;
  int unsigned           col;
  int unsigned           x_idx;
  int unsigned           r_idx;
  logic [MAP_AW-1:0]     x_off;
  logic [RES_AW-1:0]     res_off;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] pick;

  // True when x must replace acc; ties keep acc.
  function automatic logic beats(input logic [DATA_WIDTH-1:0] xv,
                                 input logic [DATA_WIDTH-1:0] av);
    logic [DATA_WIDTH-2:0] mx;
    logic [DATA_WIDTH-2:0] ma;
    mx = xv[DATA_WIDTH-2:0];
    ma = av[DATA_WIDTH-2:0];
    if (FLOAT_MODE == 0) return $signed(xv) > $signed(av);
    // +0 and -0 compare equal, so the earlier one stays.
    if (mx == '0 && ma == '0) return 1'b0;
    if (xv[DATA_WIDTH-1] != av[DATA_WIDTH-1]) return ~xv[DATA_WIDTH-1];
    if (!xv[DATA_WIDTH-1]) return mx > ma;
    return mx < ma;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
`ifdef RELU_EN
    // MSB flags a negative in both number formats; -0 folds to +0.
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    row     = 32'(i_q) * P + 32'(wr_q);
    col     = 32'(j_q) * P + 32'(wc_q);
    x_idx   = (32'(k_q) * H + row) * W + col;
    r_idx   = (32'(k_q) * OH + 32'(i_q)) * OW + 32'(j_q);
    x_off   = MAP_AW'(x_idx * DATA_WIDTH);
    res_off = RES_AW'(r_idx * DATA_WIDTH);
    x       = bus.maps[x_off +: DATA_WIDTH];
    pick    = acc_q;
    if ((wr_q == '0 && wc_q == '0) || beats(x, acc_q)) pick = x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StScan;
            busy_q  <= 1'b1;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
          end
        end
        StScan: begin
          acc_q <= pick;
          if (wc_q != PW'(P - 1)) begin
            wc_q <= wc_q + 1'b1;
          end else begin
            wc_q <= '0;
            if (wr_q != PW'(P - 1)) begin
              wr_q <= wr_q + 1'b1;
            end else begin
              // Last element of the window: commit the result and move to the next window.
              wr_q                         <= '0;
              res_q[res_off +: DATA_WIDTH] <= relu(pick);
              if (j_q != JW'(OW - 1)) begin
                j_q <= j_q + 1'b1;
              end else begin
                j_q <= '0;
                if (i_q != IW'(OH - 1)) begin
                  i_q <= i_q + 1'b1;
                end else begin
                  i_q <= '0;
                  if (k_q != KW'(K - 1)) begin
                    k_q <= k_q + 1'b1;
                  end else begin
                    k_q     <= '0;
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                end
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: four parameterisations (SInt 4x4, float 2x2,
// defaults with a reference model, SInt 5x5 with unread trailing row/column).
module tb_max_pool_layer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  max_pool_layer_if #(.DATA_WIDTH(32), .K(1), .H(4), .W(4), .P(2)) if_a ();
  max_pool_layer_if #(.DATA_WIDTH(32), .K(1), .H(2), .W(2), .P(2)) if_b ();
  max_pool_layer_if #(.DATA_WIDTH(32), .K(6), .H(28), .W(28), .P(2)) if_c ();
  max_pool_layer_if #(.DATA_WIDTH(32), .K(1), .H(5), .W(5), .P(2)) if_d ();

  max_pool_layer #(.DATA_WIDTH(32), .FLOAT_MODE(0), .K(1), .H(4), .W(4), .P(2))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  max_pool_layer #(.DATA_WIDTH(32), .FLOAT_MODE(1), .K(1), .H(2), .W(2), .P(2))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  max_pool_layer u_c (.clk(clk), .rst(rst), .bus(if_c));
  max_pool_layer #(.DATA_WIDTH(32), .FLOAT_MODE(0), .K(1), .H(5), .W(5), .P(2))
    u_d (.clk(clk), .rst(rst), .bus(if_d));

  typedef struct {
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;
    logic [31:0] raw;
  } fvec_t;

  fvec_t       fv [8];
  logic [31:0] va [16];
  logic [31:0] mc [6][28][28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Sign-magnitude float as a signed number: both zeros map to 0 and compare equal.
  function automatic logic signed [32:0] fkey(input logic [31:0] v);
    logic signed [32:0] m;
    m = {2'b00, v[30:0]};
    return v[31] ? -m : m;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       if_a.start = v;
      1:       if_b.start = v;
      2:       if_c.start = v;
      default: if_d.start = v;
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return if_a.done;
      1:       return if_b.done;
      2:       return if_c.done;
      default: return if_d.done;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return if_a.busy;
      1:       return if_b.busy;
      2:       return if_c.busy;
      default: return if_d.busy;
    endcase
  endfunction

  // One-cycle start; lat = cycle index (start edge = 0) showing done, -1 on timeout.
  task automatic kick(input int which, input int bound, output int lat, output int nb);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1 set_start(which, 1'b0);
    lat = -1;
    nb  = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (busy_of(which)) nb++;
      if (done_of(which)) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_a(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    int lat;
    int nb;
    for (int e = 0; e < 16; e++) if_a.maps[9'(e * 32) +: 32] = va[e];
    kick(0, 40, lat, nb);
    check({tag, "_latency"}, lat, 17);
    check({tag, "_busy_cycles"}, nb, 16);
    check({tag, "_res0"}, if_a.res[0 +: 32], relu(e0));
    check({tag, "_res1"}, if_a.res[32 +: 32], relu(e1));
    check({tag, "_res2"}, if_a.res[64 +: 32], relu(e2));
    check({tag, "_res3"}, if_a.res[96 +: 32], relu(e3));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(if_a.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nb;
    int nd;
    logic seen;
    logic [31:0] acc;
    logic [31:0] xv;

    fv[0] = '{32'hC0400000, 32'hBFC00000, 32'hC0000000, 32'hBF000000, 32'hBF000000};
    fv[1] = '{32'h80000000, 32'h00000000, 32'hC0000000, 32'h3F800000, 32'h3F800000};
    fv[2] = '{32'hBF800000, 32'h40000000, 32'h3F800000, 32'hC0800000, 32'h40000000};
    fv[3] = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000};
    fv[4] = '{32'h00000000, 32'h80000000, 32'hBF800000, 32'h80000000, 32'h00000000};
    fv[5] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40A00000, 32'h40A00000};
    fv[6] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7FC00000, 32'h00000001, 32'h7FC00000};
    fv[7] = '{32'hFFC00000, 32'hFF800000, 32'hC0000000, 32'h80000001, 32'h80000001};

    if_a.start = 1'b0; if_a.maps = '0;
    if_b.start = 1'b0; if_b.maps = '0;
    if_c.start = 1'b0; if_c.maps = '0;
    if_d.start = 1'b0; if_d.maps = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_busy", 32'(if_a.busy), 32'd0);
    check("rst_a_done", 32'(if_a.done), 32'd0);
    for (int e = 0; e < 4; e++)
      check($sformatf("rst_a_res%0d", e), if_a.res[7'(e * 32) +: 32], 32'd0);
    check("rst_c_busy", 32'(if_c.busy), 32'd0);
    rst = 1'b0;

    // SInt 4x4 ascending, then sign-sensitive and all-negative patterns.
    for (int e = 0; e < 16; e++) va[e] = 32'(e + 1);
    run_a("a_asc", 32'd6, 32'd8, 32'd14, 32'd16);
    for (int e = 0; e < 16; e++) va[e] = (e % 2 == 1) ? 32'(-e) : 32'(e);
    run_a("a_mixed", 32'd4, 32'd6, 32'd12, 32'd14);
    for (int e = 0; e < 16; e++) va[e] = 32'(-(e + 1));
    run_a("a_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF7, 32'hFFFFFFF5);

    // Reset held for 3 cycles in the middle of a scan.
    for (int e = 0; e < 16; e++) if_a.maps[9'(e * 32) +: 32] = 32'(e + 1);
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1 if_a.start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", 32'(if_a.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(if_a.busy), 32'd0);
    check("midrst_done", 32'(if_a.done), 32'd0);
    for (int e = 0; e < 4; e++)
      check($sformatf("midrst_res%0d", e), if_a.res[7'(e * 32) +: 32], 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen = seen | if_a.done | if_a.busy;
    end
    check("midrst_no_done_after", 32'(seen), 32'd0);

    // Float 2x2 ordering vectors.
    for (int v = 0; v < 8; v++) begin
      if_b.maps[0 +: 32]  = fv[v].x0;
      if_b.maps[32 +: 32] = fv[v].x1;
      if_b.maps[64 +: 32] = fv[v].x2;
      if_b.maps[96 +: 32] = fv[v].x3;
      kick(1, 20, lat, nb);
      check($sformatf("fvec%0d_latency", v), lat, 5);
      check($sformatf("fvec%0d_res", v), if_b.res[0 +: 32], relu(fv[v].raw));
    end

    // 5x5 with P=2: row 4 and column 4 are never read.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if_d.maps[10'((r * 5 + c) * 32) +: 32] =
          (r == 4 || c == 4) ? 32'h7FFFFFFF : 32'(r * 5 + c + 1);
    kick(3, 40, lat, nb);
    check("d_latency", lat, 17);
    check("d_res0", if_d.res[0 +: 32], relu(32'd7));
    check("d_res1", if_d.res[32 +: 32], relu(32'd9));
    check("d_res2", if_d.res[64 +: 32], relu(32'd17));
    check("d_res3", if_d.res[96 +: 32], relu(32'd19));

    // Defaults with random maps; a second start mid-scan must be ignored.
    for (int k = 0; k < 6; k++)
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++) begin
          mc[k][r][c] = $urandom;
          if_c.maps[18'(((k * 28 + r) * 28 + c) * 32) +: 32] = mc[k][r][c];
        end
    @(negedge clk);
    if_c.start = 1'b1;
    @(posedge clk);
    #1 if_c.start = 1'b0;
    nb  = 0;
    nd  = 0;
    lat = -1;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      if (c == 100) if_c.start = 1'b1;
      else if (c == 101) if_c.start = 1'b0;
      if (if_c.busy) nb++;
      if (if_c.done) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (lat > 0 && c >= lat + 50) break;
    end
    check("c_latency", lat, 4705);
    check("c_busy_cycles", nb, 4704);
    check("c_done_pulses", nd, 1);
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 14; i++)
        for (int j = 0; j < 14; j++) begin
          acc = mc[k][2 * i][2 * j];
          for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++) begin
              xv = mc[k][2 * i + wr][2 * j + wc];
              if (fkey(xv) > fkey(acc)) acc = xv;
            end
          check($sformatf("c_res_%0d_%0d_%0d", k, i, j),
                if_c.res[16'(((k * 14 + i) * 14 + j) * 32) +: 32], relu(acc));
        end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
